// File: rtl/spi_reg_bridge.sv
// SPI byte stream to register bus: command byte {RnW, Addr[6:0]} then data bytes.
// Define SPI_REG_BRIDGE_ERR_EN to build the saturating protocol error counter.
module spi_reg_bridge #(
    parameter int AUTO_INC = 1,
    parameter int RD_LAT   = 1
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Rx_Valid,
    input  logic [7:0] Rx_Data,
    input  logic       Frame_Start,
    input  logic       Frame_End,
    output logic       Tx_Valid,
    output logic [7:0] Tx_Data,
    output logic [6:0] Reg_Addr,
    output logic       Reg_Wr_En,
    output logic [7:0] Reg_Wr_Data,
    output logic       Reg_Rd_En,
    input  logic [7:0] Reg_Rd_Data,
    output logic       Busy,
    output logic [7:0] Err_Cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_WR,
        S_RD_REQ,
        S_RD_WAIT,
        S_RD_DATA
    } state_e;

    localparam logic [1:0] LAT  = 2'(RD_LAT);
    localparam logic       AINC = (AUTO_INC != 0);

    state_e     state_q, state_d;
    logic [6:0] addr_q, addr_d;
    logic       wr_en_q, wr_en_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic       rd_en_q, rd_en_d;
    logic       tx_valid_q, tx_valid_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic [1:0] wait_q, wait_d;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wr_en_d    = 1'b0;
        wr_data_d  = wr_data_q;
        rd_en_d    = 1'b0;
        tx_valid_d = 1'b0;
        tx_data_d  = tx_data_q;
        wait_d     = wait_q;

        // Address advances only after the strobe cycle has shown it.
        if (wr_en_q && AINC) begin
            addr_d = addr_q + 7'd1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (Frame_Start) begin
                    state_d = S_CMD;
                end
            end
            S_CMD: begin
                if (Rx_Valid) begin
                    addr_d = Rx_Data[6:0];
                    if (Rx_Data[7]) begin
                        state_d = S_RD_REQ;
                        rd_en_d = 1'b1;
                    end else begin
                        state_d = S_WR;
                    end
                end
            end
            S_WR: begin
                if (Rx_Valid) begin
                    wr_en_d   = 1'b1;
                    wr_data_d = Rx_Data;
                end
            end
            S_RD_REQ: begin
                state_d = S_RD_WAIT;
                wait_d  = 2'd1;
            end
            S_RD_WAIT: begin
                if (wait_q == LAT) begin
                    tx_data_d  = Reg_Rd_Data;
                    tx_valid_d = 1'b1;
                    state_d    = S_RD_DATA;
                end else begin
                    wait_d = wait_q + 2'd1;
                end
            end
            S_RD_DATA: begin
                if (Rx_Valid) begin
                    if (AINC) begin
                        addr_d = addr_q + 7'd1;
                    end
                    state_d = S_RD_REQ;
                    rd_en_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Frame_End drops any pending read; a coincident write still goes out.
        if (Frame_End) begin
            state_d    = S_IDLE;
            rd_en_d    = 1'b0;
            tx_valid_d = 1'b0;
            tx_data_d  = tx_data_q;
        end

        if (Frame_Start && state_q != S_IDLE) begin
            state_d    = S_CMD;
            rd_en_d    = 1'b0;
            tx_valid_d = 1'b0;
            tx_data_d  = tx_data_q;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            wr_en_q    <= 1'b0;
            wr_data_q  <= '0;
            rd_en_q    <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            wait_q     <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wr_en_q    <= wr_en_d;
            wr_data_q  <= wr_data_d;
            rd_en_q    <= rd_en_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            wait_q     <= wait_d;
        end
    end

    assign Tx_Valid    = tx_valid_q;
    assign Tx_Data     = tx_data_q;
    assign Reg_Addr    = addr_q;
    assign Reg_Wr_En   = wr_en_q;
    assign Reg_Wr_Data = wr_data_q;
    assign Reg_Rd_En   = rd_en_q;
    assign Busy        = (state_q != S_IDLE);

`ifdef SPI_REG_BRIDGE_ERR_EN
    logic       err_evt;
    logic [7:0] err_q;

    // Restart mid-frame, or a frame closed before any command byte.
    assign err_evt = (Frame_Start && state_q != S_IDLE)
                   || (Frame_End && state_q == S_CMD && !Rx_Valid);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            err_q <= '0;
        end else if (err_evt && err_q != 8'hFF) begin
            err_q <= err_q + 8'd1;
        end
    end

    assign Err_Cnt = err_q;
`else
    assign Err_Cnt = '0;
`endif

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Self-checking bench for spi_reg_bridge: directed and randomized frames
// against a frame-level model of expected writes and read-back bytes.
module tb_spi_reg_bridge;

    localparam int RD_LAT = 2;

`ifdef SPI_REG_BRIDGE_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       Rx_Valid = 1'b0;
    logic [7:0] Rx_Data = '0;
    logic       Frame_Start = 1'b0;
    logic       Frame_End = 1'b0;
    logic       Tx_Valid;
    logic [7:0] Tx_Data;
    logic [6:0] Reg_Addr;
    logic       Reg_Wr_En;
    logic [7:0] Reg_Wr_Data;
    logic       Reg_Rd_En;
    logic [7:0] Reg_Rd_Data = '0;
    logic       Busy;
    logic [7:0] Err_Cnt;

    spi_reg_bridge #(.AUTO_INC(1), .RD_LAT(RD_LAT)) dut (
        .Clk(Clk), .Rst(Rst), .Rx_Valid(Rx_Valid), .Rx_Data(Rx_Data),
        .Frame_Start(Frame_Start), .Frame_End(Frame_End),
        .Tx_Valid(Tx_Valid), .Tx_Data(Tx_Data), .Reg_Addr(Reg_Addr),
        .Reg_Wr_En(Reg_Wr_En), .Reg_Wr_Data(Reg_Wr_Data),
        .Reg_Rd_En(Reg_Rd_En), .Reg_Rd_Data(Reg_Rd_Data),
        .Busy(Busy), .Err_Cnt(Err_Cnt)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [6:0] a;
        logic [7:0] d;
    } wr_t;

    int         n_chk = 0;
    int         n_pass = 0;
    int         cyc = 0;
    int         last_rx_cyc = 0;
    int         rd_due = -1;
    logic [7:0] rd_due_data = '0;
    bit         both_seen = 1'b0;
    logic [7:0] mem [128];
    wr_t        wr_q [$];
    logic [7:0] tx_q [$];
    int         tx_cyc_q [$];

    always @(posedge Clk) cyc <= cyc + 1;

    // Monitor plus register model answering reads RD_LAT cycles after the strobe.
    always @(negedge Clk) begin
        if (Reg_Wr_En) wr_q.push_back({Reg_Addr, Reg_Wr_Data});
        if (Tx_Valid) begin
            tx_q.push_back(Tx_Data);
            tx_cyc_q.push_back(cyc);
        end
        if (Reg_Wr_En && Reg_Rd_En) both_seen = 1'b1;
        if (cyc == rd_due) Reg_Rd_Data = rd_due_data;
        else Reg_Rd_Data = 8'($urandom);
        if (Reg_Rd_En) begin
            rd_due = cyc + RD_LAT;
            rd_due_data = mem[Reg_Addr];
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge Clk);
    endtask

    task automatic pulse_start();
        Frame_Start = 1'b1;
        tick();
        Frame_Start = 1'b0;
    endtask

    task automatic pulse_end();
        Frame_End = 1'b1;
        tick();
        Frame_End = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        Rx_Valid = 1'b1;
        Rx_Data = b;
        last_rx_cyc = cyc;
        tick();
        Rx_Valid = 1'b0;
        Rx_Data = 8'($urandom);
        if (gap > 1) tick(gap - 1);
    endtask

    task automatic drive_write(input logic [6:0] a, input logic [7:0] d[$],
                               input int gapmax);
        pulse_start();
        send_byte({1'b0, a}, $urandom_range(1, gapmax));
        foreach (d[i]) send_byte(d[i], $urandom_range(1, gapmax));
        tick(2);
        pulse_end();
        tick(2);
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        tick(2);
        Rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        logic [7:0] d[$];
        Rst = 1'b1;
        Rx_Valid = 1'b1;
        Frame_Start = 1'b1;
        tick(3);
        Rx_Valid = 1'b0;
        Frame_Start = 1'b0;
        n_chk++;
        if ({Tx_Valid, Tx_Data, Reg_Addr, Reg_Wr_En, Reg_Wr_Data,
             Reg_Rd_En, Err_Cnt} !== '0)
            $display("FAIL reset_outputs: got tx=%b/%h addr=%h wr=%b/%h rd=%b err=%h, want all 0",
                     Tx_Valid, Tx_Data, Reg_Addr, Reg_Wr_En, Reg_Wr_Data, Reg_Rd_En, Err_Cnt);
        else n_pass++;
        n_chk++;
        if (Busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", Busy);
        else n_pass++;
        Rst = 1'b0;
        tick();
        wr_q.delete();
        d = {8'h77};
        send_byte(8'h21, 2);
        send_byte(8'h77, 3);
        n_chk++;
        if (wr_q.size() != 0 || Busy !== 1'b0)
            $display("FAIL idle_ignores_rx: got %0d writes busy=%b, want 0 writes busy=0",
                     wr_q.size(), Busy);
        else n_pass++;
    endtask

    task automatic test_write_basic();
        logic [7:0] d[$];
        wr_q.delete();
        d = {8'hAA, 8'hBB};
        drive_write(7'h12, d, 3);
        n_chk++;
        if (wr_q.size() != 2) $display("FAIL wr_basic_count: got %0d want 2", wr_q.size());
        else n_pass++;
        if (wr_q.size() == 2) begin
            n_chk++;
            if (wr_q[0] !== {7'h12, 8'hAA} || wr_q[1] !== {7'h13, 8'hBB})
                $display("FAIL wr_basic_data: got %h:%h %h:%h want 12:aa 13:bb",
                         wr_q[0].a, wr_q[0].d, wr_q[1].a, wr_q[1].d);
            else n_pass++;
        end
    endtask

    task automatic test_write_wrap();
        logic [7:0] d[$];
        wr_q.delete();
        d = {8'h01, 8'h02};
        drive_write(7'h7F, d, 2);
        n_chk++;
        if (wr_q.size() != 2 || wr_q[0] !== {7'h7F, 8'h01} || wr_q[1] !== {7'h00, 8'h02})
            $display("FAIL wr_wrap: got %0d writes, first %h, want 7f:01 then 00:02",
                     wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : 15'h0);
        else n_pass++;
    endtask

    task automatic test_write_random(input int gapmax, input int frames);
        for (int f = 0; f < frames; f++) begin
            logic [6:0] a;
            logic [7:0] d[$];
            int len;
            a = 7'($urandom);
            len = $urandom_range(1, 5);
            for (int i = 0; i < len; i++) d.push_back(8'($urandom));
            wr_q.delete();
            drive_write(a, d, gapmax);
            n_chk++;
            if (wr_q.size() != len)
                $display("FAIL wr_rand_count: frame %0d got %0d want %0d", f, wr_q.size(), len);
            else n_pass++;
            for (int i = 0; i < len && i < wr_q.size(); i++) begin
                n_chk++;
                if (wr_q[i] !== {7'(int'(a) + i), d[i]})
                    $display("FAIL wr_rand_item: frame %0d item %0d got %h:%h want %h:%h",
                             f, i, wr_q[i].a, wr_q[i].d, 7'(int'(a) + i), d[i]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_read_basic();
        mem[7'h10] = 8'h5C;
        mem[7'h11] = 8'h6D;
        tx_q.delete();
        tx_cyc_q.delete();
        pulse_start();
        send_byte(8'h90, RD_LAT + 4);
        n_chk++;
        if (tx_q.size() != 1 || tx_q[0] !== 8'h5C)
            $display("FAIL rd_first: got %0d bytes first %h, want 1 byte 5c",
                     tx_q.size(), (tx_q.size() > 0) ? tx_q[0] : 8'h0);
        else n_pass++;
        if (tx_cyc_q.size() > 0) begin
            n_chk++;
            if (tx_cyc_q[0] - last_rx_cyc != RD_LAT + 2)
                $display("FAIL rd_latency: got %0d cycles want %0d",
                         tx_cyc_q[0] - last_rx_cyc, RD_LAT + 2);
            else n_pass++;
        end
        send_byte(8'($urandom), RD_LAT + 4);
        n_chk++;
        if (tx_q.size() != 2 || tx_q[1] !== 8'h6D)
            $display("FAIL rd_second: got %0d bytes last %h, want 2 bytes last 6d",
                     tx_q.size(), tx_q[tx_q.size() - 1]);
        else n_pass++;
        pulse_end();
        tick(RD_LAT + 4);
        n_chk++;
        if (tx_q.size() != 2) $display("FAIL rd_after_end: got %0d bytes want 2", tx_q.size());
        else n_pass++;
    endtask

    task automatic test_read_random();
        for (int f = 0; f < 4; f++) begin
            logic [6:0] a;
            int k;
            a = 7'($urandom);
            k = $urandom_range(1, 4);
            tx_q.delete();
            wr_q.delete();
            pulse_start();
            send_byte({1'b1, a}, RD_LAT + 3 + $urandom_range(0, 3));
            for (int i = 0; i < k; i++) begin
                if (i < k - 1) begin
                    send_byte(8'($urandom), RD_LAT + 3 + $urandom_range(0, 3));
                end else begin
                    send_byte(8'($urandom), 1);
                    pulse_end();
                end
            end
            tick(RD_LAT + 4);
            n_chk++;
            if (tx_q.size() != k || wr_q.size() != 0)
                $display("FAIL rd_rand_count: frame %0d got %0d tx %0d wr, want %0d tx 0 wr",
                         f, tx_q.size(), wr_q.size(), k);
            else n_pass++;
            for (int i = 0; i < k && i < tx_q.size(); i++) begin
                n_chk++;
                if (tx_q[i] !== mem[7'(int'(a) + i)])
                    $display("FAIL rd_rand_item: frame %0d byte %0d got %h want %h",
                             f, i, tx_q[i], mem[7'(int'(a) + i)]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_end_with_byte();
        wr_q.delete();
        pulse_start();
        send_byte(8'h20, 2);
        send_byte(8'h11, 2);
        Rx_Valid = 1'b1;
        Rx_Data = 8'h22;
        Frame_End = 1'b1;
        tick();
        Rx_Valid = 1'b0;
        Frame_End = 1'b0;
        n_chk++;
        if (Reg_Wr_En !== 1'b1 || Reg_Addr !== 7'h21 || Reg_Wr_Data !== 8'h22)
            $display("FAIL end_with_byte_wr: got en=%b %h:%h want 1 21:22",
                     Reg_Wr_En, Reg_Addr, Reg_Wr_Data);
        else n_pass++;
        tick();
        n_chk++;
        if (Busy !== 1'b0 || wr_q.size() != 2)
            $display("FAIL end_with_byte_idle: got busy=%b writes=%0d want 0 and 2",
                     Busy, wr_q.size());
        else n_pass++;
        tick(2);
    endtask

    task automatic test_restart();
        do_reset();
        wr_q.delete();
        pulse_start();
        send_byte(8'h30, 2);
        send_byte(8'h01, 2);
        pulse_start();
        send_byte(8'h40, 2);
        send_byte(8'h02, 3);
        pulse_end();
        tick(2);
        n_chk++;
        if (wr_q.size() != 2 || wr_q[0] !== {7'h30, 8'h01} || wr_q[1] !== {7'h40, 8'h02})
            $display("FAIL restart_writes: got %0d writes want 30:01 40:02", wr_q.size());
        else n_pass++;
        n_chk++;
        if (Err_Cnt !== (ERR_EN ? 8'd1 : 8'd0))
            $display("FAIL restart_err: got %0d want %0d", Err_Cnt, ERR_EN ? 1 : 0);
        else n_pass++;
    endtask

    task automatic test_err_cnt();
        do_reset();
        for (int i = 0; i < 300; i++) begin
            pulse_start();
            pulse_end();
            if (i == 2) begin
                n_chk++;
                if (Err_Cnt !== (ERR_EN ? 8'd3 : 8'd0))
                    $display("FAIL err_cnt_3: got %0d want %0d", Err_Cnt, ERR_EN ? 3 : 0);
                else n_pass++;
            end
        end
        tick();
        n_chk++;
        if (Err_Cnt !== (ERR_EN ? 8'hFF : 8'h00))
            $display("FAIL err_cnt_sat: got %h want %h", Err_Cnt, ERR_EN ? 8'hFF : 8'h00);
        else n_pass++;
    endtask

    task automatic test_reset_mid_read();
        tx_q.delete();
        pulse_start();
        Rx_Valid = 1'b1;
        Rx_Data = 8'h85;
        tick();
        Rx_Valid = 1'b0;
        tick();
        Rst = 1'b1;
        tick();
        n_chk++;
        if ({Tx_Valid, Tx_Data, Reg_Addr, Reg_Wr_En, Reg_Wr_Data,
             Reg_Rd_En, Busy, Err_Cnt} !== '0)
            $display("FAIL midread_rst_outputs: got tx=%b addr=%h rd=%b busy=%b, want all 0",
                     Tx_Valid, Reg_Addr, Reg_Rd_En, Busy);
        else n_pass++;
        Rst = 1'b0;
        tick(RD_LAT + 6);
        n_chk++;
        if (tx_q.size() != 0) $display("FAIL midread_no_tx: got %0d tx want 0", tx_q.size());
        else n_pass++;
        wr_q.delete();
        send_byte(8'h44, 3);
        pulse_end();
        tick();
        pulse_start();
        send_byte(8'h05, 2);
        send_byte(8'h33, 3);
        pulse_end();
        tick(2);
        n_chk++;
        if (wr_q.size() != 1 || wr_q[0] !== {7'h05, 8'h33})
            $display("FAIL midread_next_frame: got %0d writes want one 05:33", wr_q.size());
        else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
        tick();
        test_reset();
        test_write_basic();
        test_write_wrap();
        test_write_random(4, 4);
        test_write_random(1, 3);
        test_read_basic();
        test_read_random();
        test_end_with_byte();
        test_restart();
        test_err_cnt();
        test_reset_mid_read();
        n_chk++;
        if (both_seen) $display("FAIL strobe_exclusive: got both strobes high want never");
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
